alu_seq: RTL and testbench

Parametrised, registered successor to the combinational 32-bit ALU.
- Executes the same eight logic/arithmetic ops in one cycle, plus barrel shifts and an iterative unsigned multiply that returns a double-width product.
- A start/busy/done handshake lets a controller or testbench sequence operations on a single clock.
- Produces carry, signed-overflow, zero and illegal-opcode flags.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_mul_seq.sv | 68 ++++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_MOV  = 4'b0000;
  localparam logic [3:0] OP_NOT  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_MUL
  } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// N-cycle shift-add unsigned multiplier; prod and fin are valid combinationally on the last
// iteration so the parent can register the product on the same edge the multiplier finishes.
module alu_mul_seq #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           fin,
  output logic [2*N-1:0] prod
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  logic [2*N-1:0] acc_q, acc_d, acc_step;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [N:0]     partial;

  // acc holds {running high word, remaining multiplier bits}; each step adds then shifts right.
  always_comb begin
    partial  = {1'b0, acc_q[2*N-1:N]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    acc_step = {partial, acc_q[N-1:1]};
  end

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (go && !busy_q) begin
      acc_d   = {{N{1'b0}}, b};
      mcand_d = a;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LastCnt) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign fin  = busy_q && (cnt_q == LastCnt);
  assign prod = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arithmetic/shift ops plus an N-cycle unsigned multiply,
// sequenced by a start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   mux_in,
  input  logic [N-1:0] in1_val,
  input  logic [N-1:0] in2_val,
  input  logic         c_in,
  output logic [N-1:0] out1_val,
  output logic [N-1:0] out2_val,
  output logic         c_out,
  output logic         ovf,
  output logic         zero,
  output logic         err,
  output logic         busy,
  output logic         done
);

  localparam int unsigned SW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   out1_q, out1_d, out2_q, out2_d;
  logic           c_out_q, c_out_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;
  logic           done_q, done_d;

  logic           is_mul, is_sub, mul_go, mul_busy, mul_fin;
  logic [2*N-1:0] mul_prod;
  logic [N-1:0]   b_eff;
  logic           cin_eff;
  logic [N:0]     sum;
  logic           add_ovf;
  logic [SW-1:0]  shamt;
  logic [N-1:0]   res;
  logic           res_c, res_v, res_err;

  assign is_mul = (mux_in == OP_MULU);
  assign is_sub = (mux_in == OP_SUB) || (mux_in == OP_SLT);
  assign mul_go = start && (state_q == ST_IDLE) && is_mul;

  alu_mul_seq #(
    .N(N)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (mul_go),
    .a    (in1_val),
    .b    (in2_val),
    .busy (mul_busy),
    .fin  (mul_fin),
    .prod (mul_prod)
  );

  // One adder serves ADD, SUB and SLT; SLT uses sign XOR overflow so it survives A-B overflow.
  always_comb begin
    b_eff   = is_sub ? ~in2_val : in2_val;
    cin_eff = is_sub ? 1'b1 : ((mux_in == OP_ADD) ? c_in : 1'b0);
    sum     = {1'b0, in1_val} + {1'b0, b_eff} + {{N{1'b0}}, cin_eff};
    add_ovf = (in1_val[N-1] == b_eff[N-1]) && (sum[N-1] != in1_val[N-1]);
    shamt   = in2_val[SW-1:0];
  end

  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    unique case (mux_in)
      OP_MOV:  res = in1_val;
      OP_NOT:  res = ~in1_val;
      OP_ADD, OP_SUB: begin
        res   = sum[N-1:0];
        res_c = sum[N];
        res_v = add_ovf;
      end
      OP_NOR:  res = ~(in1_val | in2_val);
      OP_NAND: res = ~(in1_val & in2_val);
      OP_AND:  res = in1_val & in2_val;
      OP_SLT:  res = {{(N-1){1'b0}}, sum[N-1] ^ add_ovf};
      OP_MULU: res = '0;
      OP_SLL:  res = in1_val << shamt;
      OP_SRL:  res = in1_val >> shamt;
      OP_SRA:  res = $signed(in1_val) >>> shamt;
      default: res_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul) begin
            state_d = ST_MUL;
          end else begin
            out1_d  = res;
            out2_d  = '0;
            c_out_d = res_c;
            ovf_d   = res_v;
            zero_d  = (res == '0);
            err_d   = res_err;
            done_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_fin) begin
          state_d = ST_IDLE;
          out1_d  = mul_prod[N-1:0];
          out2_d  = mul_prod[2*N-1:N];
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
          zero_d  = (mul_prod[N-1:0] == '0);
          err_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out1_q  <= '0;
      out2_q  <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign out1_val = out1_q;
  assign out2_val = out2_q;
  assign c_out    = c_out_q;
  assign ovf      = ovf_q;
  assign zero     = zero_q;
  assign err      = err_q;
  assign busy     = mul_busy;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq (N=32) against an arithmetic reference model.
module tb_alu_seq;

  localparam int unsigned N = 32;

  logic          clk = 1'b0;
  logic          rst, start, c_in;
  logic [3:0]    mux_in;
  logic [N-1:0]  in1_val, in2_val, out1_val, out2_val;
  logic          c_out, ovf, zero, err, busy, done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [31:0] o1;
    logic [31:0] o2;
    logic        c;
    logic        v;
    logic        z;
    logic        e;
  } exp_t;

  alu_seq #(
    .N(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mux_in   (mux_in),
    .in1_val  (in1_val),
    .in2_val  (in2_val),
    .c_in     (c_in),
    .out1_val (out1_val),
    .out2_val (out2_val),
    .c_out    (c_out),
    .ovf      (ovf),
    .zero     (zero),
    .err      (err),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    exp_t        r;
    longint      sa, sb, t;
    logic [32:0] s;
    logic [63:0] p;
    logic [4:0]  amt;
    r   = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    amt = b[4:0];
    case (op)
      4'd0: r.o1 = a;
      4'd1: r.o1 = ~a;
      4'd2: begin
        s    = {1'b0, a} + {1'b0, b} + 33'(cin);
        r.o1 = s[31:0];
        r.c  = s[32];
        t    = sa + sb + longint'(cin);
        r.v  = (t != longint'($signed(t[31:0])));
      end
      4'd3: r.o1 = ~(a | b);
      4'd4: begin
        r.o1 = a - b;
        r.c  = (a >= b);
        t    = sa - sb;
        r.v  = (t != longint'($signed(t[31:0])));
      end
      4'd5: r.o1 = ~(a & b);
      4'd6: r.o1 = a & b;
      4'd7: r.o1 = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: begin
        p    = 64'(a) * 64'(b);
        r.o1 = p[31:0];
        r.o2 = p[63:32];
      end
      4'd9:  r.o1 = a << amt;
      4'd10: r.o1 = a >> amt;
      4'd11: r.o1 = $signed(a) >>> amt;
      default: r.e = 1'b1;
    endcase
    r.z = (r.o1 == 32'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".out1"}, 64'(out1_val), 64'(e.o1));
    check({tag, ".out2"}, 64'(out2_val), 64'(e.o2));
    check({tag, ".c_out"}, 64'(c_out), 64'(e.c));
    check({tag, ".ovf"}, 64'(ovf), 64'(e.v));
    check({tag, ".zero"}, 64'(zero), 64'(e.z));
    check({tag, ".err"}, 64'(err), 64'(e.e));
  endtask

  // Issue one op; for MULU, checks busy/done every cycle until the product lands.
  // With inject set, a stray ADD start is pulsed mid-multiply and must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input bit inject);
    exp_t e;
    @(negedge clk);
    mux_in = op; in1_val = a; in2_val = b; c_in = cin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(op, a, b, cin);
    if (op == 4'd8) begin
      check({tag, ".busy_e0"}, 64'(busy), 64'd1);
      check({tag, ".done_e0"}, 64'(done), 64'd0);
      for (int i = 1; i < 32; i++) begin
        @(negedge clk);
        in1_val = $urandom;
        in2_val = $urandom;
        mux_in  = 4'd2;
        start   = (inject && i == 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_mid"}, 64'(busy), 64'd1);
        check({tag, ".done_mid"}, 64'(done), 64'd0);
      end
      @(posedge clk);
      #1;
      check({tag, ".busy_end"}, 64'(busy), 64'd0);
    end
    check({tag, ".done"}, 64'(done), 64'd1);
    check_outputs(tag, e);
  endtask

  task automatic check_reset_state(input string tag);
    exp_t e;
    e   = '0;
    e.z = 1'b1;
    check_outputs(tag, e);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    rst = 1'b1; start = 1'b0; mux_in = '0; in1_val = '0; in2_val = '0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op("add_ff", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("add_cin", 4'd2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_ovf", 4'd4, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
    run_op("slt_ovf", 4'd7, 32'h7FFF_FFFF, 32'h8000_0001, 1'b0, 1'b0);
    run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 1'b0);
    run_op("mul_ff", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("sra", 4'd11, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
    run_op("srl", 4'd10, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
    run_op("sll", 4'd9, 32'h0000_0001, 32'h0000_0021, 1'b0, 1'b0);
    run_op("illegal", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);

    // Back-to-back single-cycle ops: each run_op re-asserts start before the next edge.
    run_op("b2b_421", 4'd0, 32'd421, 32'd0, 1'b0, 1'b0);
    run_op("b2b_3", 4'd0, 32'd3, 32'd0, 1'b0, 1'b0);
    run_op("b2b_76", 4'd0, 32'd76, 32'd0, 1'b0, 1'b0);
    held = 32'd76;
    @(posedge clk);
    #1;
    check("idle_done", 64'(done), 64'd0);
    check("idle_hold", 64'(out1_val), 64'(held));

    // Reset 10 cycles into a multiply, with start also high on the reset edge.
    @(negedge clk);
    mux_in = 4'd8; in1_val = 32'h0001_0003; in2_val = 32'h0000_0007; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mux_in = 4'd0; in1_val = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check_reset_state("mul_abort");
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_abort_done", 64'(done), 64'd0);
    run_op("add_5_12", 4'd2, 32'd5, 32'd12, 1'b0, 1'b0);

    for (int i = 0; i < 120; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = ra;
        default: ;
      endcase
      run_op("rand", rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
